// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Core reset sequencer for the FPGA top level.
//               - Holds the console core in reset until the PLL has locked
//                 and a power-up delay has elapsed.
//               - Hold-to-reset on the board button (2-flop synchronised),
//                 with a minimum reset pulse once it fires.
//               - Free-running heartbeat toggle for a status LED.
//               Optional macro: RESET_SEQ_RELOCK_EN -- when defined, loss
//               of PLL lock in any state returns to WAIT_LOCK and re-runs
//               the power-up delay.
// Ports       : clk          pixel clock
//               rst_n        synchronous active-low block reset
//               pll_locked   PLL lock indication
//               btn_reset_n  raw reset button, active-low, asynchronous
//               core_rst_n   registered active-low reset to the core
//               heartbeat    toggles every HEARTBEAT_CYCLES edges
//               reset_count  saturating count of button-triggered resets
//               state        current FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
  parameter int POWERUP_CYCLES   = 16,
  parameter int HOLD_CYCLES      = 25200000,
  parameter int MIN_RESET_CYCLES = 16,
  parameter int HEARTBEAT_CYCLES = 25200000,
  parameter int CNT_W            = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       btn_reset_n,
  output logic       core_rst_n,
  output logic       heartbeat,
  output logic [7:0] reset_count,
  output logic [2:0] state
);

  localparam logic [2:0] c_WAIT_LOCK = 3'd0;
  localparam logic [2:0] c_POWERUP   = 3'd1;
  localparam logic [2:0] c_RUN       = 3'd2;
  localparam logic [2:0] c_ARMED     = 3'd3;
  localparam logic [2:0] c_RESET     = 3'd4;

  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_PU_LAST  = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_HLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_MIN_LAST = CNT_W'(MIN_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_HB_LAST  = CNT_W'(HEARTBEAT_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             w_btn_pressed;
  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [7:0]       rc_q;
  logic [7:0]       rc_d;
  logic             core_rst_n_q;
  logic [CNT_W-1:0] hb_cnt_q;
  logic             hb_q;

  assign w_btn_pressed = ~sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rc_d    = rc_q;
    case (state_q)
      c_WAIT_LOCK: begin
        if (pll_locked) begin
          state_d = c_POWERUP;
          cnt_d   = '0;
        end
      end
      c_POWERUP: begin
        if (cnt_q == c_PU_LAST) begin
          state_d = c_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end
      c_RUN: begin
        if (w_btn_pressed) begin
          state_d = c_ARMED;
          cnt_d   = '0;
        end
      end
      c_ARMED: begin
        // A release before the hold time expires is a short press: ignore it.
        if (!w_btn_pressed) begin
          state_d = c_RUN;
          cnt_d   = '0;
        end else if (cnt_q == c_HLD_LAST) begin
          state_d = c_RESET;
          cnt_d   = '0;
          if (rc_q != 8'hFF) begin
            rc_d = rc_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end
      c_RESET: begin
        // Counter saturates so a held button keeps the core in reset.
        if (!w_btn_pressed && (cnt_q == c_MIN_LAST)) begin
          state_d = c_POWERUP;
          cnt_d   = '0;
        end else if (cnt_q != c_MIN_LAST) begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end
      default: begin
        state_d = c_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
`ifdef RESET_SEQ_RELOCK_EN
    // Lock loss overrides every other transition, including a pending
    // button reset, so the reset count is held as well.
    if ((state_q != c_WAIT_LOCK) && !pll_locked) begin
      state_d = c_WAIT_LOCK;
      cnt_d   = '0;
      rc_d    = rc_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= c_WAIT_LOCK;
      cnt_q        <= '0;
      rc_q         <= 8'd0;
      core_rst_n_q <= 1'b0;
      hb_cnt_q     <= '0;
      hb_q         <= 1'b0;
    end else begin
      sync1_q      <= btn_reset_n;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rc_q         <= rc_d;
      // Registered from next state so the core sees a glitch-free reset.
      core_rst_n_q <= (state_d == c_RUN) || (state_d == c_ARMED);
      if (hb_cnt_q == c_HB_LAST) begin
        hb_cnt_q <= '0;
        hb_q     <= ~hb_q;
      end else begin
        hb_cnt_q <= hb_cnt_q + c_CNT_ONE;
      end
    end
  end

  assign core_rst_n  = core_rst_n_q;
  assign heartbeat   = hb_q;
  assign reset_count = rc_q;
  assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Directed self-checking bench for reset_sequencer with
//               POWERUP=4, HOLD=8, MIN_RESET=16, HEARTBEAT=5. Expectations
//               for lock loss follow the RESET_SEQ_RELOCK_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       btn_reset_n;
  logic       core_rst_n;
  logic       heartbeat;
  logic [7:0] reset_count;
  logic [2:0] state;

  int tests_run;
  int tests_failed;

  reset_sequencer #(
    .POWERUP_CYCLES   (4),
    .HOLD_CYCLES      (8),
    .MIN_RESET_CYCLES (16),
    .HEARTBEAT_CYCLES (5),
    .CNT_W            (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .btn_reset_n (btn_reset_n),
    .core_rst_n  (core_rst_n),
    .heartbeat   (heartbeat),
    .reset_count (reset_count),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle past it; inputs changed after this
  // are sampled at the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    pll_locked  = 1'b1;
    btn_reset_n = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (state !== 3'd0 || core_rst_n !== 1'b0 || heartbeat !== 1'b0 || reset_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_values: got state=%0d core_rst_n=%b hb=%b rc=%0d, want 0 0 0 0",
               state, core_rst_n, heartbeat, reset_count);
    end
  endtask

  task automatic test_powerup();
    logic [2:0] exp_st;
    logic       exp_core;
    rst_n = 1'b1;
    for (int e = 0; e < 6; e++) begin
      tick();
      exp_st   = (e < 4) ? 3'd1 : 3'd2;
      exp_core = (e < 4) ? 1'b0 : 1'b1;
      tests_run++;
      if (state !== exp_st || core_rst_n !== exp_core) begin
        tests_failed++;
        $display("FAIL powerup edge %0d: got state=%0d core=%b, want state=%0d core=%b",
                 e, state, core_rst_n, exp_st, exp_core);
      end
    end
  endtask

  task automatic test_short_press();
    logic [2:0] exp_st [8];
    exp_st = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd2};
    btn_reset_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 4) btn_reset_n = 1'b1;
      tests_run++;
      if (state !== exp_st[i] || core_rst_n !== 1'b1) begin
        tests_failed++;
        $display("FAIL short_press edge %0d: got state=%0d core=%b, want state=%0d core=1",
                 i, state, core_rst_n, exp_st[i]);
      end
    end
    tests_run++;
    if (reset_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL short_press_count: got %0d, want 0", reset_count);
    end
  endtask

  task automatic test_hold_reset();
    logic [2:0] exp_st;
    logic       exp_core;
    btn_reset_n = 1'b0;
    // j indexes edges from k, the edge at which sync1 first samples low.
    for (int j = 0; j <= 30; j++) begin
      tick();
      if (j == 12) btn_reset_n = 1'b1;
      if (j < 2)       exp_st = 3'd2;
      else if (j < 10) exp_st = 3'd3;
      else if (j < 26) exp_st = 3'd4;
      else if (j < 30) exp_st = 3'd1;
      else             exp_st = 3'd2;
      exp_core = (j < 10 || j == 30) ? 1'b1 : 1'b0;
      tests_run++;
      if (state !== exp_st || core_rst_n !== exp_core) begin
        tests_failed++;
        $display("FAIL hold_reset edge k+%0d: got state=%0d core=%b, want state=%0d core=%b",
                 j, state, core_rst_n, exp_st, exp_core);
      end
      if (j == 10) begin
        tests_run++;
        if (reset_count !== 8'd1) begin
          tests_failed++;
          $display("FAIL hold_reset_count: got %0d, want 1", reset_count);
        end
      end
    end
  endtask

  task automatic test_relock();
    logic [2:0] exp_st   [7];
    logic       exp_core [7];
`ifdef RESET_SEQ_RELOCK_EN
    exp_st   = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2};
    exp_core = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    exp_st   = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
    exp_core = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    pll_locked = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 1) pll_locked = 1'b1;
      tests_run++;
      if (state !== exp_st[i] || core_rst_n !== exp_core[i]) begin
        tests_failed++;
        $display("FAIL relock edge %0d: got state=%0d core=%b, want state=%0d core=%b",
                 i, state, core_rst_n, exp_st[i], exp_core[i]);
      end
    end
    tests_run++;
    if (reset_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL relock_count: got %0d, want 1", reset_count);
    end
  endtask

  task automatic test_wait_lock();
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    repeat (2) tick();
    tests_run++;
    if (reset_count !== 8'd0 || state !== 3'd0 || core_rst_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL midseq_reset: got rc=%0d state=%0d core=%b, want 0 0 0",
               reset_count, state, core_rst_n);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests_run++;
      if (state !== 3'd0 || core_rst_n !== 1'b0) begin
        tests_failed++;
        $display("FAIL wait_lock edge %0d: got state=%0d core=%b, want 0 0",
                 i, state, core_rst_n);
      end
    end
    pll_locked = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (state !== ((i < 4) ? 3'd1 : 3'd2) || core_rst_n !== ((i < 4) ? 1'b0 : 1'b1)) begin
        tests_failed++;
        $display("FAIL lock_powerup edge L+%0d: got state=%0d core=%b, want state=%0d core=%b",
                 i, state, core_rst_n, (i < 4) ? 1 : 2, (i < 4) ? 0 : 1);
      end
    end
  endtask

  task automatic test_heartbeat();
    logic exp_hb;
    rst_n = 1'b0;
    repeat (2) tick();
    tests_run++;
    if (heartbeat !== 1'b0) begin
      tests_failed++;
      $display("FAIL hb_reset: got %b, want 0", heartbeat);
    end
    rst_n = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      exp_hb = (((e + 1) / 5) % 2) == 1;
      tests_run++;
      if (heartbeat !== exp_hb) begin
        tests_failed++;
        $display("FAIL hb edge %0d: got %b, want %b", e, heartbeat, exp_hb);
      end
      if (e == 6) break;
    end
    // Heartbeat is high here; a mid-period reset must clear it and restart
    // the period count.
    rst_n = 1'b0;
    tick();
    tests_run++;
    if (heartbeat !== 1'b0 || state !== 3'd0) begin
      tests_failed++;
      $display("FAIL hb_midreset: got hb=%b state=%0d, want 0 0", heartbeat, state);
    end
    rst_n = 1'b1;
    for (int e = 0; e < 6; e++) begin
      tick();
      exp_hb = (e >= 4);
      tests_run++;
      if (heartbeat !== exp_hb) begin
        tests_failed++;
        $display("FAIL hb_restart edge %0d: got %b, want %b", e, heartbeat, exp_hb);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    btn_reset_n  = 1'b1;
    test_reset();
    test_powerup();
    test_short_press();
    test_hold_reset();
    test_relock();
    test_wait_lock();
    test_heartbeat();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
